mac_acc: RTL and testbench
==========================

# mac_acc

Parametrised successor to the fixed 16-lane MAC. It computes a pipelined N-lane dot product of weight and activation vectors and accumulates that sum over a multi-beat group delimited by `first_i`/`last_i`, so one result covers many input channels. Per-beat mode bits select the weight encoding (plain two's complement, or odd-symmetric 2w+1) and the activation signedness. The block sits between the weight/activation buffers and the post-processing (bias/ReLU/quantise) stage of the CNN datapath.

## Interface
- `WI`, 8: bit width of each weight and activation lane element.
- `N`, 16: lane count; must be a power of two, at least 2.
- `WN`, $clog2(N): adder-tree depth (derived; do not override).
- `WACC`, 32: accumulator and result width; must be at least 2*(WI+1)+WN.

Ports:
- `clk` in 1: clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `vld_i` in 1: input beat valid.
- `first_i` in 1: beat opens a group; sampled only with `vld_i`.
- `last_i` in 1: beat closes a group; sampled only with `vld_i`.
- `wmode_i` in 1: weight encoding. 0 = two's complement w. 1 = odd-symmetric 2w+1.
- `asgn_i` in 1: activation encoding. 1 = signed, 0 = unsigned.
- `win` in N*WI: weights; lane i is at [i*WI +: WI].
- `din` in N*WI: activations, same packing as `win`.
- `acc_o` out WACC: signed group result.
- `vld_o` out 1: single-cycle pulse; `acc_o` and `ovf_o` are valid while it is high.
- `ovf_o` out 1: the group saturated at least once.

## Operation
- **Stage 0 (input register).** Each lane is extended to WI+1 bits.
  - Weight, mode 0: sign-extend w. Mode 1: {w,1'b1}, which equals 2w+1.
  - Activation: sign-extend when `asgn_i`=1, zero-extend when 0.
  - `vld_i`, `first_i` and `last_i` are registered alongside the data.
- **Multipliers.** N combinational signed multiplies, each producing WP = 2*(WI+1) bits.
- **Adder tree.** WN registered levels. Level k output width is WP+k; every add is signed with sign extension. Tree result width is WT = WP+WN.
- **Sideband.** The control flags travel in a shift register of depth WN+1, aligned with the tree data.
- **Accumulator.** Updates only on a valid tree beat, with sum = sign-extended tree result:
  - `first`=1: acc = sum, and the sticky overflow flag is cleared before this beat's check.
  - `first`=0: acc = sat(acc + sum).
  - sat clamps to [-2^(WACC-1), 2^(WACC-1)-1]. Any clamp sets the sticky flag.
- **Group close.** On a beat with `last`=1, `acc_o` is loaded with the new acc value and `ovf_o` with the sticky flag (including this beat). `vld_o` pulses in the same cycle.
- **Held outputs.** `acc_o` and `ovf_o` hold between pulses.
- **Boundary cases:**
  - `first` and `last` on the same beat: a single-beat group.
  - A beat with `first`=0 after a completed group: it accumulates onto the held acc. There is no implicit clear.
  - `first` mid-group: discards the partial sum and restarts.
  - Idle cycles (`vld_i`=0) inside a group are allowed and do not change acc.
- **Free-running datapath.** Data registers update every cycle. Only the accumulator, the sticky flag and the outputs are gated by valid.

## Timing
- Reset: all pipeline registers, acc, sticky flag, `acc_o`, `vld_o` and `ovf_o` are 0. A reset mid-group discards all in-flight beats; no `vld_o` is produced for them.
- Throughput: one beat per cycle, no backpressure.
- Latency: a `last` beat sampled at edge t produces `vld_o`=1 after edge t+WN+2. For N=16 that is 6 cycles.
- Back-to-back single-beat groups produce a `vld_o` every cycle.

## Structure
- Package `mac_pkg`:
  - width helper functions: WP(WI), WT(WI,N);
  - encoding constants WMODE_TC=0 and WMODE_ODD=1.
- Sub-module `mac_tree`:
  - parametrised N-lane multiply plus registered adder tree, built with generate loops;
  - carries the valid/flag sideband.
- `mac_acc` holds:
  - the input stage;
  - the saturating accumulator;
  - the output registers.

## Test plan
- **Single-beat, odd-symmetric:** N=16, mode 1, unsigned, w=0, din=1, first=last=1 -> 6 cycles later `vld_o`=1, `acc_o`=16, `ovf_o`=0.
- **Two's complement, unsigned:** mode 0, w=0xFF, din=0xFF, single beat -> `acc_o`=-4080.
- **Signed activations:** mode 0, `asgn_i`=1, w=0x80, din=0x80 -> `acc_o`=262144. Then mode 1, w=0x7F, din=0xFF unsigned -> `acc_o`=1040400.
- **Multi-beat group with gap:**
  - Beats: first beat with mode 1, w=0, din=1; one idle cycle; then two more beats, the last with last=1.
  - Required: exactly one `vld_o`, `acc_o`=48, and `vld_o` exactly 6 cycles after the last beat.
- **Saturation:** WACC=24, 9-beat group, mode 1, w=0x7F, din=0xFF -> `acc_o`=8388607, `ovf_o`=1. The next single-beat group (w=0, din=1) -> `acc_o`=16, `ovf_o`=0.
- **Reset mid-group:** assert `rstn`=0 two cycles after a group's `last` beat -> no `vld_o`, and all outputs are 0. A fresh single-beat group after release returns the correct result at 6 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, encodings and sideband type for the mac_acc dot-product accumulator.
package mac_pkg;

   localparam logic WMODE_TC  = 1'b0;
   localparam logic WMODE_ODD = 1'b1;

   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } mac_flags_t;

   function automatic int WP(input int wi);
      return 2 * (wi + 1);
   endfunction

   function automatic int WT(input int wi, input int n);
      return WP(wi) + $clog2(n);
   endfunction

endpackage

// File: rtl/mac_tree.sv
// N-lane signed multiply feeding a registered binary adder tree; the control
// flags ride a shift register that stays aligned with the tree result.
module mac_tree
   import mac_pkg::*;
#(
   parameter int WI = 8,
   parameter int N  = 16,
   parameter int WN = $clog2(N)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [N*(WI+1)-1:0]        w_i,
   input  logic [N*(WI+1)-1:0]        a_i,
   input  mac_flags_t                 fl_i,
   output logic signed [WT(WI,N)-1:0] sum_o,
   output mac_flags_t                 fl_o
);

   localparam int WE  = WI + 1;
   localparam int WPR = WP(WI);

   logic signed [WPR-1:0] prod [N];

   for (genvar l = 0; l < N; l++) begin : g_mul
      logic signed [WE-1:0] wl, al;
      assign wl      = w_i[l*WE +: WE];
      assign al      = a_i[l*WE +: WE];
      assign prod[l] = wl * al;
   end

   // Level k holds N>>k partial sums, each one bit wider than level k-1.
   for (genvar k = 1; k <= WN; k++) begin : g_lvl
      localparam int WK = WPR + k;
      for (genvar j = 0; j < (N >> k); j++) begin : g_add
         logic signed [WK-1:0] lhs, rhs, sum_q;
         if (k == 1) begin : g_src
            assign lhs = WK'(prod[2*j]);
            assign rhs = WK'(prod[2*j+1]);
         end else begin : g_src
            assign lhs = WK'(g_lvl[k-1].g_add[2*j].sum_q);
            assign rhs = WK'(g_lvl[k-1].g_add[2*j+1].sum_q);
         end
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) sum_q <= '0;
            else       sum_q <= lhs + rhs;
         end
      end
   end

   assign sum_o = g_lvl[WN].g_add[0].sum_q;

   mac_flags_t sb_q [WN];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < WN; i++) sb_q[i] <= '0;
      end else begin
         sb_q[0] <= fl_i;
         for (int i = 1; i < WN; i++) sb_q[i] <= sb_q[i-1];
      end
   end

   assign fl_o = sb_q[WN-1];

endmodule

// File: rtl/mac_acc.sv
// Pipelined N-lane dot product with a saturating group accumulator between the
// weight/activation buffers and post-processing.
module mac_acc
   import mac_pkg::*;
#(
   parameter int WI   = 8,
   parameter int N    = 16,
   parameter int WN   = $clog2(N),
   parameter int WACC = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   vld_i,
   input  logic                   first_i,
   input  logic                   last_i,
   input  logic                   wmode_i,
   input  logic                   asgn_i,
   input  logic [N*WI-1:0]        win,
   input  logic [N*WI-1:0]        din,
   output logic signed [WACC-1:0] acc_o,
   output logic                   vld_o,
   output logic                   ovf_o
);

   localparam int WE  = WI + 1;
   localparam int WTR = WT(WI, N);

   // Stream has no ready: every beat with vld_i=1 is consumed on that edge.
   logic [N*WE-1:0] w_d, w_q, a_d, a_q;
   mac_flags_t      fl_d, fl_q, tr_fl;
   logic signed [WTR-1:0] tr_sum;

   always_comb begin
      w_d = '0;
      a_d = '0;
      for (int l = 0; l < N; l++) begin
         if (wmode_i == WMODE_ODD) w_d[l*WE +: WE] = {win[l*WI +: WI], 1'b1};
         else                      w_d[l*WE +: WE] = {win[l*WI+WI-1], win[l*WI +: WI]};
         a_d[l*WE +: WE] = {asgn_i & din[l*WI+WI-1], din[l*WI +: WI]};
      end
      fl_d.vld   = vld_i;
      fl_d.first = vld_i & first_i;
      fl_d.last  = vld_i & last_i;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_q  <= '0;
         a_q  <= '0;
         fl_q <= '0;
      end else begin
         w_q  <= w_d;
         a_q  <= a_d;
         fl_q <= fl_d;
      end
   end

   mac_tree #(.WI(WI), .N(N), .WN(WN)) u_tree (
      .clk   (clk),
      .rstn  (rstn),
      .w_i   (w_q),
      .a_i   (a_q),
      .fl_i  (fl_q),
      .sum_o (tr_sum),
      .fl_o  (tr_fl)
   );

   logic signed [WACC-1:0] acc_d, acc_q, sum_ext, base;
   logic signed [WACC:0]   tot;
   logic                   sat, sticky_d, sticky_q, close_d, close_q;

   // One guard bit catches overflow; a first beat adds onto zero instead of acc.
   always_comb begin
      sum_ext  = WACC'(tr_sum);
      base     = tr_fl.first ? '0 : acc_q;
      tot      = (WACC+1)'(base) + (WACC+1)'(sum_ext);
      sat      = tot[WACC] != tot[WACC-1];
      acc_d    = acc_q;
      sticky_d = sticky_q;
      if (tr_fl.vld) begin
         if (sat) acc_d = tot[WACC] ? {1'b1, {(WACC-1){1'b0}}} : {1'b0, {(WACC-1){1'b1}}};
         else     acc_d = tot[WACC-1:0];
         sticky_d = (sticky_q & ~tr_fl.first) | sat;
      end
      close_d = tr_fl.vld & tr_fl.last;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q    <= '0;
         sticky_q <= 1'b0;
         close_q  <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         sticky_q <= sticky_d;
         close_q  <= close_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_o <= '0;
         ovf_o <= 1'b0;
         vld_o <= 1'b0;
      end else begin
         vld_o <= close_q;
         if (close_q) begin
            acc_o <= acc_q;
            ovf_o <= sticky_q;
         end
      end
   end

endmodule

// File: tb/tb_mac_acc.sv
// Directed and randomized checks of mac_acc at WACC=32 and WACC=24 against a
// plain-arithmetic dot-product/saturation model.
module tb_mac_acc;

   localparam int WI  = 8;
   localparam int N   = 16;
   localparam int LAT = $clog2(N) + 2;

   logic clk = 1'b0, rstn = 1'b0;
   logic vld_i = 1'b0, first_i = 1'b0, last_i = 1'b0, wmode_i = 1'b0, asgn_i = 1'b0;
   logic [N*WI-1:0] win = '0, din = '0;
   logic signed [31:0] acc32;
   logic signed [23:0] acc24;
   logic vld32, ovf32, vld24, ovf24;

   int checks = 0, errors = 0, cyc = 0, last_edge = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int     cyc;
      longint a32;
      bit     o32;
      longint a24;
      bit     o24;
   } exp_t;
   exp_t exp_q[$];

   longint m_acc32 = 0, m_acc24 = 0;
   bit     m_ovf32 = 1'b0, m_ovf24 = 1'b0;

   mac_acc #(.WI(WI), .N(N)) u_dut32 (
      .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
      .wmode_i(wmode_i), .asgn_i(asgn_i), .win(win), .din(din),
      .acc_o(acc32), .vld_o(vld32), .ovf_o(ovf32)
   );

   mac_acc #(.WI(WI), .N(N), .WACC(24)) u_dut24 (
      .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
      .wmode_i(wmode_i), .asgn_i(asgn_i), .win(win), .din(din),
      .acc_o(acc24), .vld_o(vld24), .ovf_o(ovf24)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [N*WI-1:0] vec(input logic [WI-1:0] v);
      return {N{v}};
   endfunction

   function automatic logic [N*WI-1:0] rnd_vec();
      logic [N*WI-1:0] r;
      for (int i = 0; i < N*WI/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference: weight value is w or 2w+1, activation signed or unsigned.
   function automatic longint dot(input logic [N*WI-1:0] w, input logic [N*WI-1:0] a,
                                  input bit m, input bit s);
      longint tot;
      tot = 0;
      for (int l = 0; l < N; l++) begin
         logic [WI-1:0] wb, ab;
         longint wv, av;
         wb = w[l*WI +: WI];
         ab = a[l*WI +: WI];
         wv = longint'($signed(wb));
         if (m) wv = 2 * wv + 1;
         av = s ? longint'($signed(ab)) : longint'(ab);
         tot += wv * av;
      end
      return tot;
   endfunction

   task automatic model_acc(input longint s, input bit f, input int w, inout longint acc, inout bit ovf);
      longint mx, mn;
      mx = (longint'(1) << (w - 1)) - 1;
      mn = -(longint'(1) << (w - 1));
      if (f) begin
         acc = s;
         ovf = 1'b0;
      end else begin
         acc += s;
         if (acc > mx) begin acc = mx; ovf = 1'b1; end
         else if (acc < mn) begin acc = mn; ovf = 1'b1; end
      end
   endtask

   task automatic beat(input bit f, input bit l, input bit m, input bit s,
                       input logic [N*WI-1:0] w, input logic [N*WI-1:0] d);
      longint p;
      @(negedge clk);
      vld_i = 1'b1; first_i = f; last_i = l; wmode_i = m; asgn_i = s; win = w; din = d;
      p = dot(w, d, m, s);
      model_acc(p, f, 32, m_acc32, m_ovf32);
      model_acc(p, f, 24, m_acc24, m_ovf24);
      last_edge = cyc + 1;
      if (l) exp_q.push_back('{cyc + 1 + LAT, m_acc32, m_ovf32, m_acc24, m_ovf24});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         vld_i = 1'b0; first_i = 1'($urandom); last_i = 1'($urandom);
         wmode_i = 1'($urandom); asgn_i = 1'($urandom);
         win = rnd_vec(); din = rnd_vec();
      end
   endtask

   task automatic wait_res(input string tag, input longint a32, input bit o32,
                           input longint a24, input bit o24);
      int lat;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vld_i = 1'b0;
         if (vld32 === 1'b1) begin
            lat = cyc - last_edge;
            break;
         end
      end
      chk({tag, "_lat"}, lat, LAT);
      chk({tag, "_acc32"}, acc32, a32);
      chk({tag, "_ovf32"}, ovf32, o32);
      chk({tag, "_acc24"}, acc24, a24);
      chk({tag, "_ovf24"}, ovf24, o24);
      @(negedge clk);
      chk({tag, "_hold"}, acc32, a32);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         bit   ev;
         exp_t e;
         ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         chk("mon_vld32", vld32, ev);
         chk("mon_vld24", vld24, ev);
         if (ev) begin
            e = exp_q.pop_front();
            chk("mon_acc32", acc32, e.a32);
            chk("mon_ovf32", ovf32, e.o32);
            chk("mon_acc24", acc24, e.a24);
            chk("mon_ovf24", ovf24, e.o24);
         end
      end
   end

   initial begin
      int  nb, gi;
      bit  big, neg, nofirst, f, m, s;
      logic [N*WI-1:0] bw, bd;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_acc32", acc32, 0);
      chk("rst_vld32", vld32, 0);
      chk("rst_ovf32", ovf32, 0);
      chk("rst_acc24", acc24, 0);
      chk("rst_vld24", vld24, 0);
      chk("rst_ovf24", ovf24, 0);
      rstn = 1'b1;
      mon_en = 1'b1;
      idle(2);

      beat(1, 1, 1, 0, vec(8'h00), vec(8'h01));
      wait_res("odd_single", 16, 0, 16, 0);

      beat(1, 1, 0, 0, vec(8'hFF), vec(8'hFF));
      wait_res("tc_unsigned", -4080, 0, -4080, 0);

      beat(1, 1, 0, 1, vec(8'h80), vec(8'h80));
      wait_res("tc_signed", 262144, 0, 262144, 0);

      beat(1, 1, 1, 0, vec(8'h7F), vec(8'hFF));
      wait_res("odd_max", 1040400, 0, 1040400, 0);

      // Multi-beat group with an idle cycle inside
      beat(1, 0, 1, 0, vec(8'h00), vec(8'h01));
      idle(1);
      beat(0, 0, 1, 0, vec(8'h00), vec(8'h01));
      beat(0, 1, 1, 0, vec(8'h00), vec(8'h01));
      wait_res("gap_group", 48, 0, 48, 0);

      // No implicit clear: a first=0 group builds on the held acc
      beat(0, 1, 1, 0, vec(8'h00), vec(8'h01));
      wait_res("no_clear", 64, 0, 64, 0);

      // Restart mid-group discards the partial sum
      beat(1, 0, 1, 0, vec(8'h7F), vec(8'hFF));
      beat(1, 1, 1, 0, vec(8'h00), vec(8'h01));
      wait_res("restart", 16, 0, 16, 0);

      // Saturation at WACC=24, then a clean group clears the sticky flag
      for (int i = 0; i < 9; i++) beat(i == 0, i == 8, 1, 0, vec(8'h7F), vec(8'hFF));
      wait_res("sat", 9363600, 0, 8388607, 1);
      beat(1, 1, 1, 0, vec(8'h00), vec(8'h01));
      wait_res("sat_next", 16, 0, 16, 0);

      // Back-to-back single-beat groups
      for (int i = 0; i < 4; i++) beat(1, 1, 1, 0, vec(8'h00), vec(WI'(i)));
      idle(LAT + 2);

      // Reset two cycles after a last beat drops the in-flight result
      beat(1, 1, 1, 0, vec(8'h7F), vec(8'hFF));
      idle(2);
      rstn = 1'b0;
      exp_q.delete();
      m_acc32 = 0; m_acc24 = 0; m_ovf32 = 1'b0; m_ovf24 = 1'b0;
      #1;
      chk("midrst_acc32", acc32, 0);
      chk("midrst_vld32", vld32, 0);
      chk("midrst_ovf32", ovf32, 0);
      chk("midrst_acc24", acc24, 0);
      idle(3);
      rstn = 1'b1;
      idle(LAT + 2);
      beat(1, 1, 1, 0, vec(8'h00), vec(8'h01));
      wait_res("post_rst", 16, 0, 16, 0);

      // Randomized groups, some long enough to saturate the 24-bit instance
      for (gi = 0; gi < 40; gi++) begin
         big     = ($urandom_range(0, 3) == 0);
         neg     = 1'($urandom);
         nofirst = ($urandom_range(0, 9) == 0);
         nb      = big ? $urandom_range(9, 11) : $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            f = ((b == 0) && !nofirst) || ($urandom_range(0, 7) == 0);
            if (big) begin
               m = 1'b1; s = 1'b0;
               bw = vec(neg ? 8'h80 : 8'h7F);
               bd = vec(8'hFF);
            end else begin
               m = 1'($urandom); s = 1'($urandom);
               bw = rnd_vec();
               bd = rnd_vec();
            end
            beat(f, b == nb - 1, m, s, bw, bd);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      idle(1);

      for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1);
      chk("drain_empty", exp_q.size(), 0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
